// File: rtl/oven_display_scan.sv
// 4-digit multiplexed 7-segment driver for the oven timer's BCD MM:SS output.
// Shadow-loads the time at frame wrap so a frame never shows a torn value; flashes on timeout.
module oven_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 100,
    parameter int ACTIVE_LOW   = 1,
    parameter int LZ_BLANK     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        time_valid,
    input  logic [15:0] time_bcd,
    input  logic        timeout,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic        POL = (ACTIVE_LOW != 0);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_pending;
    logic [15:0]   r_active;
    logic          r_phase;
    logic [BW-1:0] r_bcnt;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;
    logic          r_frame_done;

    logic          w_tc;
    logic          w_wrap;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_dec;
    logic [6:0]    w_seg;
    logic [3:0]    w_an;
    logic          w_lit;

    assign w_tc   = (r_presc == PRESC_LAST);
    assign w_wrap = w_tc && (r_idx == 2'd3);
    // Dropping timeout must re-light the very next cycle, so it bypasses the phase register.
    assign w_lit  = r_phase || !timeout;

    always_comb begin
        w_nibble = '0;
        case (r_idx)
            2'd0:    w_nibble = r_active[3:0];
            2'd1:    w_nibble = r_active[7:4];
            2'd2:    w_nibble = r_active[11:8];
            default: w_nibble = r_active[15:12];
        endcase
    end

    always_comb begin
        w_seg_dec = 7'h40;
        case (w_nibble)
            4'd0:    w_seg_dec = 7'h3F;
            4'd1:    w_seg_dec = 7'h06;
            4'd2:    w_seg_dec = 7'h5B;
            4'd3:    w_seg_dec = 7'h4F;
            4'd4:    w_seg_dec = 7'h66;
            4'd5:    w_seg_dec = 7'h6D;
            4'd6:    w_seg_dec = 7'h7D;
            4'd7:    w_seg_dec = 7'h07;
            4'd8:    w_seg_dec = 7'h7F;
            4'd9:    w_seg_dec = 7'h6F;
            default: w_seg_dec = 7'h40;
        endcase
    end

    always_comb begin
        w_seg = w_seg_dec;
        if ((LZ_BLANK != 0) && (r_idx == 2'd3) && (w_nibble == 4'd0)) begin
            w_seg = '0;
        end
        w_an = '0;
        if (w_lit) begin
            w_an[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pending    <= '0;
            r_active     <= '0;
            r_phase      <= 1'b1;
            r_bcnt       <= '0;
            r_seg        <= {7{POL}};
            r_dp         <= POL;
            r_an         <= {4{POL}};
            r_frame_done <= 1'b0;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + 1'b1;
            if (w_tc) begin
                r_idx <= r_idx + 2'd1;
            end
            if (time_valid) begin
                r_pending <= time_bcd;
            end
            if (w_wrap) begin
                r_active <= time_valid ? time_bcd : r_pending;
            end
            if (!timeout) begin
                r_phase <= 1'b1;
                r_bcnt  <= '0;
            end else if (w_wrap) begin
                if (r_bcnt == BLINK_LAST) begin
                    r_bcnt  <= '0;
                    r_phase <= !r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
            r_seg        <= w_seg ^ {7{POL}};
            r_dp         <= (r_idx == 2'd2) ^ POL;
            r_an         <= w_an ^ {4{POL}};
            r_frame_done <= w_wrap;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_oven_display_scan.sv
// Bench for oven_display_scan: edge-count reference model checked every cycle,
// plus directed loads/timeout/reset with literal expectations.
module tb_oven_display_scan;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam logic [6:0] SEG_TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        time_valid = 1'b0;
    logic [15:0] time_bcd = '0;
    logic        timeout = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    oven_display_scan #(
        .SCAN_DIV(SD),
        .BLINK_FRAMES(BF),
        .ACTIVE_LOW(0),
        .LZ_BLANK(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .time_valid(time_valid),
        .time_bcd(time_bcd),
        .timeout(timeout),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: m_e = clock edges since reset release.
    int          m_e = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_act = '0;
    bit          m_on = 1'b1;
    int          m_cnt = 0;
    logic [3:0]  exp_an = '0;
    logic [6:0]  exp_seg = '0;
    logic        exp_dp = 1'b0;
    logic        exp_fd = 1'b0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h edge=%0d", name, got, exp, m_e);
        end
    endtask

    always @(posedge clk) begin : model
        int idx;
        logic [3:0] dig;
        bit wrap;
        if (rst) begin
            m_e = 0; m_pend = '0; m_act = '0; m_on = 1'b1; m_cnt = 0;
            exp_an = '0; exp_seg = '0; exp_dp = 1'b0; exp_fd = 1'b0;
        end else begin
            m_e++;
            idx = ((m_e - 1) / SD) % 4;
            dig = m_act[idx*4 +: 4];
            exp_an  = (m_on || !timeout) ? 4'(1 << idx) : 4'b0000;
            exp_seg = (dig > 9) ? 7'h40 : SEG_TAB[dig];
            if (idx == 3 && dig == 0) exp_seg = 7'h00;
            exp_dp  = (idx == 2);
            wrap    = (m_e % (4 * SD)) == 0;
            exp_fd  = wrap;
            if (time_valid) m_pend = time_bcd;
            if (wrap) m_act = m_pend;
            if (!timeout) begin
                m_on = 1'b1;
                m_cnt = 0;
            end else if (wrap) begin
                m_cnt++;
                if (m_cnt == BF) begin
                    m_cnt = 0;
                    m_on = !m_on;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_an", 16'(an), 16'(exp_an));
        check("cyc_seg", 16'(seg), 16'(exp_seg));
        check("cyc_dp", 16'(dp), 16'(exp_dp));
        check("cyc_frame_done", 16'(frame_done), 16'(exp_fd));
    end

    task automatic run_to(input int target);
        int guard = 0;
        while (m_e != target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (m_e != target) begin
            checks++;
            failures++;
            $display("FAIL run_to got=%0d exp=%0d", m_e, target);
        end
    endtask

    task automatic strobe(input int at, input logic [15:0] v);
        run_to(at - 1);
        time_valid = 1'b1;
        time_bcd = v;
        run_to(at);
        time_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", 16'(an), 16'h0);
        check("rst_seg", 16'(seg), 16'h0);
        check("rst_dp", 16'(dp), 16'h0);
        check("rst_fd", 16'(frame_done), 16'h0);
        rst = 1'b0;

        run_to(1);  check("scan_e1_an", 16'(an), 16'h1);
        run_to(4);  check("scan_e4_an", 16'(an), 16'h1);
        strobe(6, 16'h1234);
        run_to(9);  check("tear_e9_an", 16'(an), 16'h4);
                    check("tear_e9_seg", 16'(seg), 16'h3F);
        run_to(15); check("fd_e15", 16'(frame_done), 16'h0);
        run_to(16); check("fd_e16", 16'(frame_done), 16'h1);
                    check("e16_an", 16'(an), 16'h8);
        run_to(17); check("l1234_d0_an", 16'(an), 16'h1);
                    check("l1234_d0_seg", 16'(seg), 16'h66);
        run_to(21); check("l1234_d1_seg", 16'(seg), 16'h4F);
        run_to(25); check("l1234_d2_seg", 16'(seg), 16'h5B);
                    check("l1234_d2_dp", 16'(dp), 16'h1);
        run_to(29); check("l1234_d3_seg", 16'(seg), 16'h06);

        strobe(34, 16'h0905);
        run_to(49); check("l0905_d0", 16'(seg), 16'h6D);
        run_to(53); check("l0905_d1", 16'(seg), 16'h3F);
        run_to(57); check("l0905_d2", 16'(seg), 16'h6F);
        run_to(61); check("l0905_d3_seg", 16'(seg), 16'h00);
                    check("l0905_d3_an", 16'(an), 16'h8);

        strobe(66, 16'h1A00);
        run_to(81); check("l1A00_d0", 16'(seg), 16'h3F);
        run_to(89); check("l1A00_d2", 16'(seg), 16'h40);
        run_to(93); check("l1A00_d3", 16'(seg), 16'h06);

        strobe(96, 16'h0042);
        run_to(97);  check("byp_d0", 16'(seg), 16'h5B);
        run_to(101); check("byp_d1", 16'(seg), 16'h66);
        run_to(109); check("byp_d3", 16'(seg), 16'h00);

        run_to(112); timeout = 1'b1;
        run_to(129); check("blink_e129_an", 16'(an), 16'h1);
        run_to(145); check("blink_e145_an", 16'(an), 16'h0);
        run_to(160); check("blink_e160_an", 16'(an), 16'h0);
        run_to(177); check("blink_e177_an", 16'(an), 16'h1);
        run_to(193); check("blink_e193_an", 16'(an), 16'h1);
        run_to(209); check("blink_e209_an", 16'(an), 16'h0);
        run_to(215); check("blink_e215_an", 16'(an), 16'h0);
        timeout = 1'b0;
        run_to(216); check("untimeout_an", 16'(an), 16'h2);

        strobe(219, 16'h0777);
        run_to(220);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_an", 16'(an), 16'h0);
        check("mrst_seg", 16'(seg), 16'h0);
        check("mrst_dp", 16'(dp), 16'h0);
        rst = 1'b0;
        run_to(1);  check("post_rst_d0", 16'(seg), 16'h3F);
                    check("post_rst_an", 16'(an), 16'h1);
        run_to(13); check("post_rst_d3", 16'(seg), 16'h00);
        run_to(17); check("pend_lost_d0", 16'(seg), 16'h3F);
        run_to(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
